// File: rtl/cmp_seq.sv
// -----------------------------------------------------------------------------
// cmp_seq : comparator phase sequencer
//
// Generates non-overlapping comparator clocks (cmp_p1 / cmp_p2), an
// offset-zero / precharge enable, and a one-cycle result strobe. Channels are
// served round-robin, one channel per P1/P2 loop.
//
// Run loop      : ZERO -> G2 -> P1 -> G1 -> P2 -> G2 -> P1 ...
// The G2 phase is the only decision point: leave to IDLE, insert a ZERO
// phase, or start the next P1.
//
// Ports
//   clk     in   single clock, all state updates on the rising edge
//   reset   in   asynchronous active-high reset
//   enable  in   level; high runs the sequencer, low parks it in IDLE
//   rezero  in   one-cycle request for a zero phase, held pending until served
//   cmp_p1  out  comparator phase-1 clock
//   cmp_p2  out  comparator phase-2 clock (high in IDLE)
//   zero    out  offset-zero / precharge enable
//   sample  out  strobe in the last P2 cycle: result valid for ch_sel
//   ch_sel  out  channel being converted
//   busy    out  high in every state except IDLE
// -----------------------------------------------------------------------------
module cmp_seq #(
   parameter int NCH         = 4,
   parameter int CNT_W       = 8,
   parameter int ZERO_CYCLES = 8,
   parameter int P1_CYCLES   = 4,
   parameter int P2_CYCLES   = 4,
   parameter int GAP_CYCLES  = 1,
   localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic            rezero,
   output logic            cmp_p1,
   output logic            cmp_p2,
   output logic            zero,
   output logic            sample,
   output logic [CH_W-1:0] ch_sel,
   output logic            busy
);

   // Parameter legality: a zero-length gap would let p1 and p2 touch.
   if (GAP_CYCLES < 1 || GAP_CYCLES > (2**CNT_W) - 1) begin : g_bad_gap
      $error("cmp_seq: GAP_CYCLES must be in 1..2^CNT_W-1");
   end
   if (ZERO_CYCLES < 1 || ZERO_CYCLES > (2**CNT_W) - 1) begin : g_bad_zero
      $error("cmp_seq: ZERO_CYCLES must be in 1..2^CNT_W-1");
   end
   if (P1_CYCLES < 1 || P1_CYCLES > (2**CNT_W) - 1) begin : g_bad_p1
      $error("cmp_seq: P1_CYCLES must be in 1..2^CNT_W-1");
   end
   if (P2_CYCLES < 1 || P2_CYCLES > (2**CNT_W) - 1) begin : g_bad_p2
      $error("cmp_seq: P2_CYCLES must be in 1..2^CNT_W-1");
   end
   if (NCH < 1) begin : g_bad_nch
      $error("cmp_seq: NCH must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_ZERO,
      S_G2,
      S_P1,
      S_G1,
      S_P2
   } state_t;

   localparam logic [CNT_W-1:0] ZERO_LAST = CNT_W'(ZERO_CYCLES - 1);
   localparam logic [CNT_W-1:0] P1_LAST   = CNT_W'(P1_CYCLES - 1);
   localparam logic [CNT_W-1:0] P2_LAST   = CNT_W'(P2_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NCH - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic              p1_q, p1_d;
   logic              p2_q, p2_d;
   logic              zero_q, zero_d;
   logic              sample_q, sample_d;
   logic              busy_q, busy_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         pend_q   <= 1'b0;
         ch_q     <= '0;
         p1_q     <= 1'b0;
         p2_q     <= 1'b1;
         zero_q   <= 1'b0;
         sample_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         ch_q     <= ch_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         zero_q   <= zero_d;
         sample_q <= sample_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      pend_d  = pend_q | rezero;
      ch_d    = ch_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (enable) state_d = S_ZERO;
         end
         S_ZERO: if (cnt_q == ZERO_LAST) state_d = S_G2;
         S_G2: begin
            if (cnt_q == GAP_LAST) begin
               if (!enable)     state_d = S_IDLE;
               else if (pend_q) state_d = S_ZERO;
               else             state_d = S_P1;
            end
         end
         S_P1: if (cnt_q == P1_LAST) state_d = S_G1;
         S_G1: if (cnt_q == GAP_LAST) state_d = S_P2;
         S_P2: begin
            if (cnt_q == P2_LAST) begin
               state_d = S_G2;
               ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Every phase starts counting from zero.
      if (state_d != state_q) cnt_d = '0;

      // Entering ZERO services the request; a rezero arriving on that same
      // edge is swallowed rather than queuing a second zero phase.
      if (state_d == S_ZERO && state_q != S_ZERO) begin
         pend_d = 1'b0;
         ch_d   = '0;
      end
      if (state_d == S_IDLE) ch_d = '0;

      // Outputs are decoded from the next state so they are registered and
      // move on the same edge as the state itself.
      p1_d     = (state_d == S_P1);
      p2_d     = (state_d == S_P2) || (state_d == S_IDLE);
      zero_d   = (state_d == S_ZERO);
      sample_d = (state_d == S_P2) && (cnt_d == P2_LAST);
      busy_d   = (state_d != S_IDLE);
   end

   assign cmp_p1 = p1_q;
   assign cmp_p2 = p2_q;
   assign zero   = zero_q;
   assign sample = sample_q;
   assign ch_sel = ch_q;
   assign busy   = busy_q;

endmodule

// File: doc/cmp_seq.md
CMP_SEQ -- requirements
Module: cmp_seq

Interface
REQ-001 Parameter NCH, default 4, number of comparator channels served round-robin (>=1).
REQ-002 Parameter CNT_W, default 8, width of the internal phase-length counter.
REQ-003 Parameter ZERO_CYCLES, default 8, length of the zero/precharge phase in clk cycles (1..2^CNT_W-1).
REQ-004 Parameter P1_CYCLES, default 4, length of cmp_p1 phase (1..2^CNT_W-1).
REQ-005 Parameter P2_CYCLES, default 4, length of cmp_p2 phase (1..2^CNT_W-1).
REQ-006 Parameter GAP_CYCLES, default 1, non-overlap gap between phases (1..2^CNT_W-1; 0 is illegal, elaboration error).
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 enable  input  1  level; high runs the sequencer, low returns it to IDLE at the cycle boundary.
REQ-010 rezero  input  1  one-cycle request to insert a zero phase; latched until serviced.
REQ-011 cmp_p1  output  1  comparator phase-1 clock.
REQ-012 cmp_p2  output  1  comparator phase-2 clock.
REQ-013 zero  output  1  comparator offset-zero/precharge enable.
REQ-014 sample  output  1  one-cycle strobe: comparator result valid for ch_sel.
REQ-015 ch_sel  output  max(1,$clog2(NCH))  channel currently being converted.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, ZERO, G2, P1, G1, P2; every output SHALL be registered and SHALL change only on the clk edge where the state changes.
REQ-018 Output decode: IDLE p1=0 p2=1 zero=0; ZERO p1=0 p2=0 zero=1; P1 p1=1 p2=0; P2 p1=0 p2=1; G1/G2 p1=0 p2=0 zero=0.
REQ-019 cmp_p1 and cmp_p2 SHALL never be high in the same cycle, and at least GAP_CYCLES cycles with both low SHALL separate each p1/p2 transition inside the run loop.
REQ-020 IDLE with enable=1 sampled -> ZERO on next edge; ZERO lasts ZERO_CYCLES, then G2.
REQ-021 G2 lasts GAP_CYCLES, P1 lasts P1_CYCLES, G1 lasts GAP_CYCLES, P2 lasts P2_CYCLES; order G2->P1->G1->P2->G2.
REQ-022 sample SHALL be high exactly in the last cycle of P2 and low otherwise.
REQ-023 ch_sel SHALL increment on the P2->G2 edge, wrapping NCH-1 -> 0; SHALL be 0 in IDLE and on entry to ZERO; constant 0 when NCH=1.
REQ-024 Decision on the last cycle of G2, priority order: enable=0 -> IDLE; rezero pending -> ZERO; else -> P1.
REQ-025 rezero SHALL set a pending flag in any state; flag cleared on entry to ZERO; a rezero coincident with ZERO entry is absorbed (no second ZERO).
REQ-026 enable deasserted in ZERO, P1, G1 or P2 SHALL NOT truncate the phase; the sequence completes through G2 before IDLE.
REQ-027 Phase counter SHALL reset to 0 on every state entry and count up to length-1; no wrap of CNT_W occurs for legal parameters.
REQ-028 Loop period with no rezero SHALL equal P1_CYCLES+P2_CYCLES+2*GAP_CYCLES cycles.

Reset
REQ-029 reset high SHALL immediately (asynchronously) force IDLE, counter 0, rezero pending 0, ch_sel 0, cmp_p1=0, cmp_p2=1, zero=0, sample=0, busy=0.
REQ-030 Reset asserted mid-phase SHALL abort the phase; after release the block waits in IDLE for enable.

Verification
REQ-031 Defaults, enable=1 after reset: zero high 8 cycles, 1 cycle gap, p1 high 4, gap 1, p2 high 4 with sample on its 4th cycle; period 10 cycles thereafter.
REQ-032 Run 5 loops: ch_sel sequence 0,1,2,3,0 at the five sample strobes; p1&p2 never both 1.
REQ-033 rezero pulse during P1 of loop 2 -> after following G2 a ZERO of 8 cycles, ch_sel=0, then normal loop.
REQ-034 enable dropped in first cycle of P1 -> P1, G1, P2 (with sample), G2 complete, then IDLE, busy=0, cmp_p2=1.
REQ-035 reset asserted in P2 cycle 2 -> outputs at IDLE values within the same cycle, no sample strobe; re-enable restarts with ZERO.
REQ-036 Parameter set GAP_CYCLES=3, P1_CYCLES=1, P2_CYCLES=2, NCH=1 -> period 9, both-low gap of 3 cycles, ch_sel constant 0.
